fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 156 +++++++++++++++
 tb/tb_fetch_unit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage with a single IF/ID pipeline register. It drives the
// fetch address to a combinational instruction memory and captures the
// returned instruction one cycle later. Stall holds the stage, redirect
// reloads the PC and squashes IF/ID, and a misaligned redirect target halts
// the stage until reset.
//
// Parameters
//   RESET_VECTOR     first fetch address after reset
//   NOP_INST         bubble instruction placed in IF/ID on squash/reset
//
// Ports
//   clk              clock, rising edge
//   rst_n            asynchronous active-low reset
//   stall            hold PC and IF/ID (hazard from decode)
//   redirect         taken branch/jump from a later stage
//   redirect_target  new fetch address, valid with redirect
//   inst_i           instruction read at pc_o (same cycle)
//   pc_o             registered fetch address
//   ifid_pc          PC of the instruction in IF/ID
//   ifid_pc4         ifid_pc + 4 (modulo 2^32)
//   ifid_inst        instruction in IF/ID
//   ifid_valid       IF/ID holds a real instruction
//   misalign_err     sticky: a redirect target was not word aligned
//   fetch_count      instructions accepted into IF/ID (wraps silently)
// ----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] NOP_INST     = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    input  logic [31:0] inst_i,
    output logic [31:0] pc_o,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc4,
    output logic [31:0] ifid_inst,
    output logic        ifid_valid,
    output logic        misalign_err,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        StBoot = 2'd0,
        StRun  = 2'd1,
        StHalt = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_pc4_q, ifid_pc4_d;
    logic [31:0] ifid_inst_q, ifid_inst_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic        misalign_q, misalign_d;
    logic [31:0] count_q, count_d;

    logic [31:0] pc_plus4;
    logic        target_misaligned;

    // Plain 32-bit adds: overflow simply wraps, which is the intended behaviour.
    assign pc_plus4          = pc_q + 32'd4;
    assign target_misaligned = (redirect_target[1:0] != 2'b00);

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_inst_d  = ifid_inst_q;
        ifid_valid_d = ifid_valid_q;
        misalign_d   = misalign_q;
        count_d      = count_q;

        case (state_q)
            // One dead cycle after reset; nothing is captured.
            StBoot: begin
                state_d = StRun;
            end

            StRun: begin
                if (redirect) begin
                    // Redirect wins over stall.
                    ifid_inst_d  = NOP_INST;
                    ifid_valid_d = 1'b0;
                    if (target_misaligned) begin
                        // PC holds; the stage stops until reset.
                        misalign_d = 1'b1;
                        state_d    = StHalt;
                    end else begin
                        pc_d = redirect_target;
                    end
                end else if (!stall) begin
                    ifid_inst_d  = inst_i;
                    ifid_pc_d    = pc_q;
                    ifid_pc4_d   = pc_plus4;
                    ifid_valid_d = 1'b1;
                    pc_d         = pc_plus4;
                    count_d      = count_q + 32'd1;
                end
            end

            StHalt: begin
                ifid_valid_d = 1'b0;
            end

            default: begin
                // Unreachable encoding: recover through the boot cycle.
                state_d      = StBoot;
                ifid_valid_d = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StBoot;
            pc_q         <= RESET_VECTOR;
            ifid_pc_q    <= 32'h0000_0000;
            ifid_pc4_q   <= 32'h0000_0000;
            ifid_inst_q  <= NOP_INST;
            ifid_valid_q <= 1'b0;
            misalign_q   <= 1'b0;
            count_q      <= 32'h0000_0000;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_inst_q  <= ifid_inst_d;
            ifid_valid_q <= ifid_valid_d;
            misalign_q   <= misalign_d;
            count_q      <= count_d;
        end
    end

    assign pc_o         = pc_q;
    assign ifid_pc      = ifid_pc_q;
    assign ifid_pc4     = ifid_pc4_q;
    assign ifid_inst    = ifid_inst_q;
    assign ifid_valid   = ifid_valid_q;
    assign misalign_err = misalign_q;
    assign fetch_count  = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed bench for fetch_unit. A small combinational memory model answers
// inst_i from pc_o; every expected value below is worked out by hand.
// ----------------------------------------------------------------------------
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_target;
    logic [31:0] inst_i;
    logic [31:0] pc_o;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc4;
    logic [31:0] ifid_inst;
    logic        ifid_valid;
    logic        misalign_err;
    logic [31:0] fetch_count;

    int n_checks;
    int n_errors;

    localparam logic [31:0] Nop = 32'h0000_0013;

    fetch_unit #(
        .RESET_VECTOR(32'h0000_0000),
        .NOP_INST    (Nop)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .redirect       (redirect),
        .redirect_target(redirect_target),
        .inst_i         (inst_i),
        .pc_o           (pc_o),
        .ifid_pc        (ifid_pc),
        .ifid_pc4       (ifid_pc4),
        .ifid_inst      (ifid_inst),
        .ifid_valid     (ifid_valid),
        .misalign_err   (misalign_err),
        .fetch_count    (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: three fixed words, elsewhere an address-derived pattern.
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        case (addr)
            32'h0000_0000: mem_word = 32'hFD01_0113;
            32'h0000_0004: mem_word = 32'h0281_2623;
            32'h0000_0008: mem_word = 32'h0301_0413;
            default:       mem_word = addr ^ 32'h5A5A_0003;
        endcase
    endfunction

    always_comb inst_i = mem_word(pc_o);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and sample 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".pc_o"},     pc_o,                32'h0000_0000);
        check({tag, ".ifid_pc"},  ifid_pc,             32'h0000_0000);
        check({tag, ".ifid_pc4"}, ifid_pc4,            32'h0000_0000);
        check({tag, ".inst"},     ifid_inst,           Nop);
        check({tag, ".valid"},    {31'd0, ifid_valid}, 32'd0);
        check({tag, ".mis"},      {31'd0, misalign_err}, 32'd0);
        check({tag, ".count"},    fetch_count,         32'd0);
    endtask

    initial begin
        n_checks        = 0;
        n_errors        = 0;
        rst_n           = 1'b1;
        stall           = 1'b0;
        redirect        = 1'b0;
        redirect_target = 32'h0;

        // Reset asserted before any clock edge.
        #1 rst_n = 1'b0;
        #1 check_reset_values("rst0");
        tick();
        tick();
        #3 rst_n = 1'b1;

        // Edge 1: boot cycle, nothing captured.
        tick();
        check("boot.valid", {31'd0, ifid_valid}, 32'd0);
        check("boot.pc",    pc_o,                32'h0);
        check("boot.count", fetch_count,         32'd0);

        // Edges 2..4: sequential fetch.
        tick();
        check("seq0.inst", ifid_inst,  32'hFD01_0113);
        check("seq0.pc",   ifid_pc,    32'h0);
        check("seq0.pc4",  ifid_pc4,   32'h4);
        check("seq0.vld",  {31'd0, ifid_valid}, 32'd1);
        tick();
        check("seq1.inst", ifid_inst,  32'h0281_2623);
        check("seq1.pc",   ifid_pc,    32'h4);
        check("seq1.pco",  pc_o,       32'h8);

        // Stall three cycles while ifid_pc = 4.
        stall = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("stall.inst",  ifid_inst,   32'h0281_2623);
        check("stall.pco",   pc_o,        32'h8);
        check("stall.count", fetch_count, 32'd2);
        stall = 1'b0;
        tick();
        check("rel.inst",  ifid_inst,   32'h0301_0413);
        check("rel.pc",    ifid_pc,     32'h8);
        check("rel.pco",   pc_o,        32'hC);
        check("rel.count", fetch_count, 32'd3);

        // Redirect and stall together: redirect wins.
        redirect        = 1'b1;
        redirect_target = 32'h10;
        stall           = 1'b1;
        tick();
        check("rdr.pco",   pc_o,                32'h10);
        check("rdr.vld",   {31'd0, ifid_valid}, 32'd0);
        check("rdr.inst",  ifid_inst,           Nop);
        check("rdr.count", fetch_count,         32'd3);
        redirect = 1'b0;
        stall    = 1'b0;
        tick();
        check("rdr2.pc",   ifid_pc,             32'h10);
        check("rdr2.vld",  {31'd0, ifid_valid}, 32'd1);
        check("rdr2.inst", ifid_inst,           32'h5A5A_0013);
        check("rdr2.cnt",  fetch_count,         32'd4);

        // PC wrap at the top of the address space.
        redirect        = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        check("wrap.pco0", pc_o, 32'hFFFF_FFFC);
        tick();
        check("wrap.pc",   ifid_pc,  32'hFFFF_FFFC);
        check("wrap.pc4",  ifid_pc4, 32'h0);
        check("wrap.pco1", pc_o,     32'h0);
        check("wrap.mis",  {31'd0, misalign_err}, 32'd0);
        tick();
        check("wrap.pco2", pc_o,      32'h4);
        check("wrap.inst", ifid_inst, 32'hFD01_0113);
        tick();
        check("pre.count", fetch_count, 32'd7);

        // Asynchronous reset between edges.
        #2 rst_n = 1'b0;
        #1 check_reset_values("arst");
        tick();
        #3 rst_n = 1'b1;
        tick();
        check("boot2.vld", {31'd0, ifid_valid}, 32'd0);
        check("boot2.cnt", fetch_count,         32'd0);
        tick();
        check("boot2.inst", ifid_inst,   32'hFD01_0113);
        check("boot2.pc",   ifid_pc,     32'h0);
        check("boot2.cnt1", fetch_count, 32'd1);

        // Misaligned redirect: halt with PC held.
        redirect        = 1'b1;
        redirect_target = 32'h6;
        tick();
        check("mis.err",  {31'd0, misalign_err}, 32'd1);
        check("mis.pco",  pc_o,                  32'h4);
        check("mis.vld",  {31'd0, ifid_valid},   32'd0);
        check("mis.inst", ifid_inst,             Nop);
        redirect_target = 32'h0;
        for (int i = 0; i < 5; i++) begin
            stall = i[0];
            tick();
        end
        redirect = 1'b0;
        stall    = 1'b0;
        tick();
        check("halt.pco",   pc_o,                  32'h4);
        check("halt.vld",   {31'd0, ifid_valid},   32'd0);
        check("halt.err",   {31'd0, misalign_err}, 32'd1);
        check("halt.count", fetch_count,           32'd1);
        check("halt.pc",    ifid_pc,               32'h0);

        // Reset out of HALT.
        #2 rst_n = 1'b0;
        #1 check_reset_values("hrst");
        #2 rst_n = 1'b1;
        tick();
        tick();
        check("post.vld",  {31'd0, ifid_valid}, 32'd1);
        check("post.inst", ifid_inst,           32'hFD01_0113);
        check("post.pco",  pc_o,                32'h4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: got no finish, expected finish before limit");
        $fatal(1);
    end

endmodule
